dec_in_packer: RTL and testbench
================================

DEC_IN_PACKER -- requirements
Module: dec_in_packer

Interface
REQ-001 SHALL have parameter WORD_ORDER, default 0, meaning 0 = first accepted word lands in block bits [127:96], 1 = first word lands in [31:0].
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port s_valid, input, 1, ciphertext word valid.
REQ-005 SHALL have port s_ready, output, 1, packer can accept a word.
REQ-006 SHALL have port s_data, input, 32, ciphertext word.
REQ-007 SHALL have port s_flush, input, 1, discard partially assembled block.
REQ-008 SHALL have port key_we, input, 1, load key_in into key register.
REQ-009 SHALL have port key_in, input, 128, cipher key for subsequent blocks.
REQ-010 SHALL have port blk_valid, output, 1, blk_data/blk_key hold a complete block.
REQ-011 SHALL have port blk_ready, input, 1, consumer takes the block.
REQ-012 SHALL have port blk_data, output, 128, assembled ciphertext block feeding decryption data_in.
REQ-013 SHALL have port blk_key, output, 128, key bound to that block, feeding decryption key.
REQ-014 SHALL have port blk_count, output, 16, number of blocks handed off, wraps modulo 2^16.

Function
REQ-015 SHALL accept a word when s_valid and s_ready are both high in the same cycle.
REQ-016 SHALL keep a 2-bit word counter cnt; each accept writes the word to the slot selected by cnt and WORD_ORDER, then increments cnt, wrapping 3 -> 0.
REQ-017 SHALL keep two 128-bit stages: an assembly register (asm) and an output register (out, with blk_valid as its full flag).
REQ-018 SHALL complete a block on accept with cnt==3.
REQ-019 On completion, if the output stage is empty or drains in the same cycle (blk_valid && blk_ready), SHALL load out directly next cycle.
REQ-020 On completion with the output stage full and not draining, SHALL set asm_full.
REQ-021 SHALL drive s_ready = !asm_full.
REQ-022 SHALL transfer asm to out, and clear asm_full, in the first cycle where the output stage is empty or draining.
REQ-023 SHALL deassert blk_valid after a cycle with blk_valid && blk_ready, unless a new block is loaded that same cycle.
REQ-024 SHALL hold blk_data and blk_key stable while blk_valid=1 and blk_ready=0.
REQ-025 SHALL load key_reg on key_we.
REQ-026 SHALL capture blk_key from key_reg at block completion, not at transfer.
REQ-027 If key_we coincides with completion, the completing block SHALL take the old key and subsequent blocks the new key.
REQ-028 SHALL increment blk_count by 1 on every cycle with blk_valid && blk_ready, wrapping 0xFFFF -> 0x0000.
REQ-029 On s_flush, SHALL clear cnt to 0 and discard the partial words.
REQ-030 s_flush SHALL NOT affect asm_full, blk_valid, blk_data, blk_key or key_reg.
REQ-031 s_flush together with an accepted word SHALL drop that word, leaving cnt=0.
REQ-032 Latency: the 4th word accepted in cycle N with the output stage empty SHALL give blk_valid=1 in cycle N+1.
REQ-033 Sustained throughput SHALL be one word per cycle with blk_ready held high, with no bubbles between blocks.

Reset
REQ-034 rst SHALL clear cnt, asm, asm_full, key_reg, blk_valid, blk_data, blk_key and blk_count to 0.
REQ-035 s_ready SHALL read 1 in the cycle after rst deasserts.
REQ-036 rst SHALL take priority over s_flush, key_we and all handshakes.
REQ-037 rst asserted mid-block or with a block pending SHALL discard everything, with no blk_valid pulse afterwards.

Structure
REQ-038 Constants BLK_W=128, WORD_W=32 and WORDS=4 SHALL live in shared package dec_pkg, also used by the decryption datapath.
REQ-039 The two-stage buffer SHALL be built as one sub-module, dec_blk_slot (data, key and full flag with load/drain), instantiated twice; the rest is flat.

Verification
REQ-040 Reset, then words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles with blk_ready=1, WORD_ORDER=0 -> blk_valid one cycle after the 4th word, blk_data=0x00112233445566778899AABBCCDDEEFF, blk_count=1.
REQ-041 blk_ready=0 while 8 words are streamed -> first block held stable; s_ready drops after the 8th word; blk_ready raised -> blocks emitted in order, blk_count=2.
REQ-042 Load key K1, send 3 words, key_we with K2 in the same cycle as the 4th word, send 4 more words -> block 1 blk_key=K1, block 2 blk_key=K2.
REQ-043 Send 2 words, then s_flush, then 4 new words -> blk_data contains only the 4 new words; a flush coinciding with an accept drops that word.
REQ-044 Preload blk_count=0xFFFF via 65535 handoffs, one more handoff -> blk_count=0x0000.
REQ-045 rst asserted with asm_full=1 and blk_valid=1 -> next cycle all outputs 0, s_ready=1, no stale block emitted afterwards.

Source files
------------

// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared constants, types and helpers for the decryption input path. The
// block/word geometry lives here so the packer and the decryption datapath
// always agree on it.
//
// Contents:
//   BLK_W, WORD_W, WORDS  - cipher block width, input word width, words/block
//   WCNT_W, BCOUNT_W      - word counter width, handed-off block counter width
//   word_order_e          - which end of the block the first word fills
//   slotOf()              - maps a word counter value to a 32-bit slot index
//   insertWord()          - returns a block with one 32-bit slot replaced
// -----------------------------------------------------------------------------
package dec_pkg;

    localparam int BLK_W    = 128;
    localparam int WORD_W   = 32;
    localparam int WORDS    = 4;
    localparam int WCNT_W   = $clog2(WORDS);
    localparam int BCOUNT_W = 16;

    typedef logic [BLK_W-1:0]  blk_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [WCNT_W-1:0] wcnt_t;

    // MSW_FIRST: first word lands in the top slot (bits [127:96]).
    // LSW_FIRST: first word lands in the bottom slot (bits [31:0]).
    typedef enum logic {
        ORDER_MSW_FIRST = 1'b0,
        ORDER_LSW_FIRST = 1'b1
    } word_order_e;

    localparam wcnt_t LAST_WORD = wcnt_t'(WORDS - 1);

    // Slot i covers bits [i*WORD_W +: WORD_W]; slot 0 is the least significant.
    function automatic wcnt_t slotOf(input wcnt_t cnt, input word_order_e order);
        return (order == ORDER_LSW_FIRST) ? cnt : (LAST_WORD - cnt);
    endfunction

    function automatic blk_t insertWord(input blk_t blk, input word_t word, input wcnt_t slot);
        blk_t res;
        res = blk;
        for (int i = 0; i < WORDS; i++) begin
            if (slot == wcnt_t'(i)) begin
                res[i*WORD_W +: WORD_W] = word;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dec_blk_slot.sv
// -----------------------------------------------------------------------------
// dec_blk_slot
// One stage of the packer's two-stage block buffer: a 128-bit data register,
// the 128-bit key bound to that data, and a full flag.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears everything)
//   wr_i      - write data_i into the data register
//   load_i    - capture key_i and mark the slot full
//   drain_i   - mark the slot empty (load_i wins if both are high)
//   data_i    - data to write
//   key_i     - key to capture
//   data_o    - stored data
//   key_o     - stored key
//   full_o    - slot holds a complete block
// -----------------------------------------------------------------------------
module dec_blk_slot
    import dec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [BLK_W-1:0] data_i,
    input  logic [BLK_W-1:0] key_i,
    output logic [BLK_W-1:0] data_o,
    output logic [BLK_W-1:0] key_o,
    output logic             full_o
);

    logic [BLK_W-1:0] data_q, data_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic             full_q, full_d;

    // A load in the same cycle as a drain keeps the slot full, so a consumer
    // taking the block and a new block arriving back-to-back leaves no bubble.
    always_comb begin
        data_d = data_q;
        key_d  = key_q;
        full_d = full_q;
        if (wr_i) begin
            data_d = data_i;
        end
        if (drain_i) begin
            full_d = 1'b0;
        end
        if (load_i) begin
            key_d  = key_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            key_q  <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            key_q  <= key_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign key_o  = key_q;
    assign full_o = full_q;

endmodule

// File: rtl/dec_in_packer.sv
// -----------------------------------------------------------------------------
// dec_in_packer
// Packs a stream of 32-bit ciphertext words into 128-bit blocks for the
// decryption core, binding each block to the key that was current when its
// last word arrived. Two block stages (assembly and output) let the input
// keep streaming while the consumer holds off for one block.
//
// Parameters:
//   WORD_ORDER - 0: first word -> bits [127:96]; 1: first word -> bits [31:0]
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   s_valid    - ciphertext word valid
//   s_ready    - packer can accept a word (low while a finished block waits)
//   s_data     - ciphertext word
//   s_flush    - discard the partially assembled block
//   key_we     - load key_in into the key register
//   key_in     - key for subsequently completed blocks
//   blk_valid  - blk_data/blk_key hold a complete block
//   blk_ready  - consumer takes the block
//   blk_data   - assembled ciphertext block
//   blk_key    - key bound to that block
//   blk_count  - number of blocks handed off, wraps modulo 2^16
// -----------------------------------------------------------------------------
module dec_in_packer
    import dec_pkg::*;
#(
    parameter int WORD_ORDER = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_flush,
    input  logic                key_we,
    input  logic [BLK_W-1:0]    key_in,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic [BLK_W-1:0]    blk_data,
    output logic [BLK_W-1:0]    blk_key,
    output logic [BCOUNT_W-1:0] blk_count
);

    localparam word_order_e ORDER = (WORD_ORDER != 0) ? ORDER_LSW_FIRST : ORDER_MSW_FIRST;

    logic [WCNT_W-1:0]   wordCnt_q, wordCnt_d;
    logic [BLK_W-1:0]    key_q, key_d;
    logic [BCOUNT_W-1:0] blkCount_q, blkCount_d;

    logic             accept;
    logic             take;
    logic             complete;
    logic             outDrain;
    logic             outRoom;
    logic             transfer;
    logic             asmLoad;
    logic             outLoad;
    logic             asmFull;
    logic [BLK_W-1:0] asmData;
    logic [BLK_W-1:0] asmKey;
    logic [BLK_W-1:0] asmNext;
    logic [BLK_W-1:0] outLoadData;
    logic [BLK_W-1:0] outLoadKey;

    // A finished block parked in the assembly stage blocks further input,
    // because that stage's data register is also where new words land.
    assign s_ready  = !asmFull;
    assign accept   = s_valid && s_ready;
    // A flush in the same cycle as an accepted word swallows that word.
    assign take     = accept && !s_flush;
    assign complete = take && (wordCnt_q == LAST_WORD);

    assign outDrain = blk_valid && blk_ready;
    assign outRoom  = !blk_valid || outDrain;
    // s_ready is low whenever asmFull is set, so transfer and complete never
    // coincide and the output stage has a single source each cycle.
    assign transfer = asmFull && outRoom;

    assign asmNext  = insertWord(asmData, s_data, slotOf(wordCnt_q, ORDER));

    // The key is bound at completion: a completing block parked in the
    // assembly stage captures key_q now, not when it later moves to output.
    // key_q still holds the old key when key_we coincides with completion.
    assign asmLoad     = complete && !outRoom;
    assign outLoad     = transfer || (complete && outRoom);
    assign outLoadData = transfer ? asmData : asmNext;
    assign outLoadKey  = transfer ? asmKey  : key_q;

    dec_blk_slot u_asm (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (take),
        .load_i  (asmLoad),
        .drain_i (transfer),
        .data_i  (asmNext),
        .key_i   (key_q),
        .data_o  (asmData),
        .key_o   (asmKey),
        .full_o  (asmFull)
    );

    dec_blk_slot u_out (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (outLoad),
        .load_i  (outLoad),
        .drain_i (outDrain),
        .data_i  (outLoadData),
        .key_i   (outLoadKey),
        .data_o  (blk_data),
        .key_o   (blk_key),
        .full_o  (blk_valid)
    );

    // Flush only rewinds the word counter; stale partial words are simply
    // overwritten by the next block, and a parked complete block is untouched.
    always_comb begin
        wordCnt_d  = wordCnt_q;
        key_d      = key_q;
        blkCount_d = blkCount_q;
        if (s_flush) begin
            wordCnt_d = '0;
        end else if (take) begin
            wordCnt_d = wordCnt_q + 1'b1;
        end
        if (key_we) begin
            key_d = key_in;
        end
        if (outDrain) begin
            blkCount_d = blkCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wordCnt_q  <= '0;
            key_q      <= '0;
            blkCount_q <= '0;
        end else begin
            wordCnt_q  <= wordCnt_d;
            key_q      <= key_d;
            blkCount_q <= blkCount_d;
        end
    end

    assign blk_count = blkCount_q;

endmodule

// File: tb/tb_dec_in_packer.sv
// -----------------------------------------------------------------------------
// tb_dec_in_packer
// Directed bench for dec_in_packer. Two instances share every input: dut uses
// WORD_ORDER=0 and dut1 uses WORD_ORDER=1. Inputs change and outputs are
// sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_dec_in_packer;

    localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] K2 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [127:0] K3 = 128'h0123456789ABCDEFFEDCBA9876543210;

    localparam logic [127:0] BLK_A = 128'h11111111222222223333333344444444;
    localparam logic [127:0] BLK_B = 128'h55555555666666667777777788888888;
    localparam logic [127:0] BLK_X = 128'h99999999AAAAAAAABBBBBBBBCCCCCCCC;
    localparam logic [127:0] BLK_C = 128'h10000000100000011000000210000003;
    localparam logic [127:0] BLK_D = 128'h20000000200000012000000220000003;
    localparam logic [127:0] BLK_E = 128'h30000000300000013000000230000003;
    localparam logic [127:0] BLK_F = 128'h40000000400000014000000240000003;
    localparam logic [127:0] BLK_G = 128'h50000000500000015000000250000003;
    localparam logic [127:0] BLK_H = 128'h60000000600000016000000260000003;
    localparam logic [127:0] BLK_I = 128'h70000000700000017000000270000003;
    localparam logic [127:0] BLK_K = 128'h80000000800000018000000280000003;
    localparam logic [127:0] BLK_L = 128'h90000000900000019000000290000003;
    localparam logic [127:0] BLK_M = 128'hA0000000A0000001A0000002A0000003;
    localparam logic [127:0] BLK_N = 128'hB0000000B0000001B0000002B0000003;
    localparam logic [127:0] BLK_P = 128'hC0000000C0000001C0000002C0000003;
    localparam logic [127:0] BLK_Q = 128'hD0000000D0000001D0000002D0000003;
    localparam logic [127:0] BLK_R = 128'hE0000000E0000001E0000002E0000003;

    logic         clk = 1'b0;
    logic         rst;
    logic         sValid;
    logic [31:0]  sData;
    logic         sFlush;
    logic         keyWe;
    logic [127:0] keyIn;
    logic         blkReady;

    logic         sReady,   sReady1;
    logic         blkValid, blkValid1;
    logic [127:0] blkData,  blkData1;
    logic [127:0] blkKey,   blkKey1;
    logic [15:0]  blkCount, blkCount1;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    dec_in_packer #(.WORD_ORDER(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (sValid),
        .s_ready   (sReady),
        .s_data    (sData),
        .s_flush   (sFlush),
        .key_we    (keyWe),
        .key_in    (keyIn),
        .blk_valid (blkValid),
        .blk_ready (blkReady),
        .blk_data  (blkData),
        .blk_key   (blkKey),
        .blk_count (blkCount)
    );

    dec_in_packer #(.WORD_ORDER(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (sValid),
        .s_ready   (sReady1),
        .s_data    (sData),
        .s_flush   (sFlush),
        .key_we    (keyWe),
        .key_in    (keyIn),
        .blk_valid (blkValid1),
        .blk_ready (blkReady),
        .blk_data  (blkData1),
        .blk_key   (blkKey1),
        .blk_count (blkCount1)
    );

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic fl);
        sValid = v;
        sData  = d;
        sFlush = fl;
        tick();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    // Sends the four words of blk, most significant word first.
    task automatic sendBlock(input logic [127:0] blk);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b1, blk[i*32 +: 32], 1'b0);
        end
    endtask

    task automatic doReset();
        rst    = 1'b1;
        sValid = 1'b0;
        sFlush = 1'b0;
        keyWe  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        sValid   = 1'b0;
        sData    = 32'h0;
        sFlush   = 1'b0;
        keyWe    = 1'b0;
        keyIn    = 128'h0;
        blkReady = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        checkOutput("rstReady", 128'(sReady), 128'h1);
        checkOutput("rstValid", 128'(blkValid), 128'h0);
        checkOutput("rstData", blkData, 128'h0);
        checkOutput("rstKey", blkKey, 128'h0);
        checkOutput("rstCount", 128'(blkCount), 128'h0);

        // Basic block, one-cycle latency, both word orders
        blkReady = 1'b1;
        applyStimulus(1'b1, 32'h00112233, 1'b0);
        applyStimulus(1'b1, 32'h44556677, 1'b0);
        applyStimulus(1'b1, 32'h8899AABB, 1'b0);
        checkOutput("t1NotYet", 128'(blkValid), 128'h0);
        applyStimulus(1'b1, 32'hCCDDEEFF, 1'b0);
        checkOutput("t1Valid", 128'(blkValid), 128'h1);
        checkOutput("t1Data", blkData, 128'h00112233445566778899AABBCCDDEEFF);
        checkOutput("t1Key", blkKey, 128'h0);
        checkOutput("t1LswValid", 128'(blkValid1), 128'h1);
        checkOutput("t1LswData", blkData1, 128'hCCDDEEFF8899AABB4455667700112233);
        checkOutput("t1LswKey", blkKey1, 128'h0);
        idle();
        checkOutput("t1Count", 128'(blkCount), 128'h1);
        checkOutput("t1Drained", 128'(blkValid), 128'h0);
        checkOutput("t1LswCount", 128'(blkCount1), 128'h1);
        checkOutput("t1LswReady", 128'(sReady1), 128'h1);

        // Back-pressure: 8 words with the consumer stalled
        doReset();
        blkReady = 1'b0;
        sendBlock(BLK_A);
        checkOutput("t2FirstValid", 128'(blkValid), 128'h1);
        checkOutput("t2FirstData", blkData, BLK_A);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b1, BLK_B[i*32 +: 32], 1'b0);
            checkOutput("t2Ready", 128'(sReady), (i == 0) ? 128'h0 : 128'h1);
            checkOutput("t2Hold", blkData, BLK_A);
        end
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
        checkOutput("t2StallReady", 128'(sReady), 128'h0);
        checkOutput("t2StallData", blkData, BLK_A);
        blkReady = 1'b1;
        idle();
        checkOutput("t2SecondValid", 128'(blkValid), 128'h1);
        checkOutput("t2SecondData", blkData, BLK_B);
        checkOutput("t2MidCount", 128'(blkCount), 128'h1);
        checkOutput("t2ReadyBack", 128'(sReady), 128'h1);
        idle();
        checkOutput("t2Count", 128'(blkCount), 128'h2);
        checkOutput("t2Empty", 128'(blkValid), 128'h0);
        sendBlock(BLK_X);
        checkOutput("t2NoStrayWord", blkData, BLK_X);
        idle();

        // Key binding at completion
        doReset();
        blkReady = 1'b1;
        keyIn = K1;
        keyWe = 1'b1;
        idle();
        keyWe = 1'b0;
        applyStimulus(1'b1, 32'h10000000, 1'b0);
        applyStimulus(1'b1, 32'h10000001, 1'b0);
        applyStimulus(1'b1, 32'h10000002, 1'b0);
        keyIn = K2;
        keyWe = 1'b1;
        applyStimulus(1'b1, 32'h10000003, 1'b0);
        keyWe = 1'b0;
        checkOutput("t3Data1", blkData, BLK_C);
        checkOutput("t3Key1", blkKey, K1);
        sendBlock(BLK_D);
        checkOutput("t3Data2", blkData, BLK_D);
        checkOutput("t3Key2", blkKey, K2);
        idle();
        blkReady = 1'b0;
        sendBlock(BLK_E);
        sendBlock(BLK_F);
        checkOutput("t3Parked", 128'(sReady), 128'h0);
        checkOutput("t3OutKey", blkKey, K2);
        keyIn = K3;
        keyWe = 1'b1;
        idle();
        keyWe = 1'b0;
        blkReady = 1'b1;
        idle();
        checkOutput("t3XferData", blkData, BLK_F);
        checkOutput("t3XferKey", blkKey, K2);
        idle();
        sendBlock(BLK_G);
        checkOutput("t3NewData", blkData, BLK_G);
        checkOutput("t3NewKey", blkKey, K3);
        idle();

        // Flush
        doReset();
        blkReady = 1'b1;
        applyStimulus(1'b1, 32'hBAD00000, 1'b0);
        applyStimulus(1'b1, 32'hBAD00001, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        sendBlock(BLK_H);
        checkOutput("t4Valid", 128'(blkValid), 128'h1);
        checkOutput("t4Data", blkData, BLK_H);
        idle();
        applyStimulus(1'b1, 32'hBAD0FFFF, 1'b1);
        applyStimulus(1'b1, 32'h70000000, 1'b0);
        applyStimulus(1'b1, 32'h70000001, 1'b0);
        applyStimulus(1'b1, 32'h70000002, 1'b0);
        checkOutput("t4DropNoEarly", 128'(blkValid), 128'h0);
        applyStimulus(1'b1, 32'h70000003, 1'b0);
        checkOutput("t4DropData", blkData, BLK_I);
        idle();
        blkReady = 1'b0;
        sendBlock(BLK_K);
        sendBlock(BLK_L);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t4FlushValid", 128'(blkValid), 128'h1);
        checkOutput("t4FlushData", blkData, BLK_K);
        checkOutput("t4FlushFull", 128'(sReady), 128'h0);
        blkReady = 1'b1;
        idle();
        checkOutput("t4FlushKept", blkData, BLK_L);
        idle();

        // blk_count wrap (preloaded to 0xFFFF)
        doReset();
        blkReady = 1'b1;
        force dut.blkCount_q = 16'hFFFF;
        tick();
        release dut.blkCount_q;
        tick();
        checkOutput("t5Preload", 128'(blkCount), 128'hFFFF);
        sendBlock(BLK_M);
        checkOutput("t5Valid", 128'(blkValid), 128'h1);
        idle();
        checkOutput("t5Wrap", 128'(blkCount), 128'h0);
        sendBlock(BLK_N);
        idle();
        checkOutput("t5AfterWrap", 128'(blkCount), 128'h1);

        // Reset with a parked block and a full output stage
        doReset();
        keyIn = K1;
        keyWe = 1'b1;
        idle();
        keyWe = 1'b0;
        blkReady = 1'b0;
        sendBlock(BLK_P);
        sendBlock(BLK_Q);
        checkOutput("t6PreFull", 128'(sReady), 128'h0);
        checkOutput("t6PreValid", 128'(blkValid), 128'h1);
        rst    = 1'b1;
        sValid = 1'b0;
        keyIn  = K2;
        keyWe  = 1'b1;
        blkReady = 1'b1;
        tick();
        keyWe = 1'b0;
        checkOutput("t6Valid", 128'(blkValid), 128'h0);
        checkOutput("t6Data", blkData, 128'h0);
        checkOutput("t6Key", blkKey, 128'h0);
        checkOutput("t6Count", 128'(blkCount), 128'h0);
        checkOutput("t6Ready", 128'(sReady), 128'h1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            checkOutput("t6NoStale", 128'(blkValid), 128'h0);
        end
        checkOutput("t6CountStill", 128'(blkCount), 128'h0);
        sendBlock(BLK_R);
        checkOutput("t6NewData", blkData, BLK_R);
        checkOutput("t6KeyCleared", blkKey, 128'h0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
